// File: rtl/idecode_sb.sv
// Registered instruction-decode stage: register file, per-register pending-write
// scoreboard for RAW/WAW interlock, optional writeback bypass, and flush.
module idecode_sb #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned SB_W   = 2,
    parameter bit          BYPASS = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic            flush,
    input  logic            wb_we,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_inst,
    output logic [4:0]      out_rs,
    output logic [4:0]      out_rt,
    output logic [4:0]      out_rd,
    output logic            out_wen,
    output logic [XLEN-1:0] out_rdata1,
    output logic [XLEN-1:0] out_rdata2,
    output logic [XLEN-1:0] out_imm
);

    localparam logic [SB_W-1:0] CNT_MAX = '1;

    logic [5:0]      op;
    logic [4:0]      dec_rs;
    logic [4:0]      dec_rt;
    logic [4:0]      dec_rd;
    logic            dec_wen;
    logic [XLEN-1:0] dec_imm;

    logic [XLEN-1:0] regs    [32];
    logic [SB_W-1:0] cnt     [32];
    logic [SB_W-1:0] cnt_nxt [32];

    logic            wb_hit;
    logic            hz_rs;
    logic            hz_rt;
    logic            hz_rd;
    logic            ready;
    logic            accept;
    logic [XLEN-1:0] opnd1;
    logic [XLEN-1:0] opnd2;
    logic            issue_inc;
    logic            wb_dec;
    logic            kill_dec;

    always_comb begin
        op     = in_inst[31:26];
        dec_rs = in_inst[25:21];
        if (op == 6'b000010 || op == 6'b000011)
            dec_rs = '0;

        dec_rt = in_inst[20:16];
        if (op == 6'b000001 || op == 6'b000010 || op == 6'b000011 || op[5:3] == 3'b100)
            dec_rt = '0;

        if (op == 6'b000000)
            dec_rd = in_inst[15:11];
        else if (op[5:3] == 3'b001 || op[5:3] == 3'b100)
            dec_rd = in_inst[20:16];
        else if (op == 6'b000001 || op == 6'b000011)
            dec_rd = 5'd31;
        else
            dec_rd = '0;

        dec_wen = (dec_rd != '0) && (in_inst != '0);

        dec_imm = {{(XLEN-16){in_inst[15]}}, in_inst[15:0]};
        case (op)
            6'b001100, 6'b001101, 6'b001110: begin
                dec_imm        = '0;
                dec_imm[15:0]  = in_inst[15:0];
            end
            6'b000010, 6'b000011: begin
                dec_imm        = '0;
                dec_imm[25:0]  = in_inst[25:0];
            end
            default: ;
        endcase
    end

    // A source waiting on exactly one write is released when that write is on the bus now.
    always_comb begin
        wb_hit = wb_we && (wb_addr != '0);
        hz_rs  = (dec_rs != '0) && (cnt[dec_rs] != '0) &&
                 !(BYPASS && wb_we && (wb_addr == dec_rs) && (cnt[dec_rs] == SB_W'(1)));
        hz_rt  = (dec_rt != '0) && (cnt[dec_rt] != '0) &&
                 !(BYPASS && wb_we && (wb_addr == dec_rt) && (cnt[dec_rt] == SB_W'(1)));
        hz_rd  = dec_wen && (cnt[dec_rd] == CNT_MAX);
        ready  = !flush && !(hz_rs || hz_rt || hz_rd) && (!out_valid || out_ready);
        accept = in_valid && ready;
    end

    assign in_ready = ready;

    always_comb begin
        if (dec_rs == '0)
            opnd1 = '0;
        else if (BYPASS && wb_hit && (wb_addr == dec_rs))
            opnd1 = wb_data;
        else
            opnd1 = regs[dec_rs];

        if (dec_rt == '0)
            opnd2 = '0;
        else if (BYPASS && wb_hit && (wb_addr == dec_rt))
            opnd2 = wb_data;
        else
            opnd2 = regs[dec_rt];
    end

    // Decrements saturate at zero so a stray writeback plus a kill cannot wrap a counter.
    always_comb begin
        issue_inc = accept && dec_wen;
        wb_dec    = wb_hit && (cnt[wb_addr] != '0);
        kill_dec  = flush && out_valid && out_wen;
        for (int unsigned r = 0; r < 32; r++) begin
            cnt_nxt[r] = cnt[r];
            if (issue_inc && (dec_rd == 5'(r)))
                cnt_nxt[r] = cnt_nxt[r] + SB_W'(1);
            if (wb_dec && (wb_addr == 5'(r)) && (cnt_nxt[r] != '0))
                cnt_nxt[r] = cnt_nxt[r] - SB_W'(1);
            if (kill_dec && (out_rd == 5'(r)) && (cnt_nxt[r] != '0))
                cnt_nxt[r] = cnt_nxt[r] - SB_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < 32; r++)
                cnt[r] <= '0;
        end else begin
            for (int unsigned r = 0; r < 32; r++)
                cnt[r] <= cnt_nxt[r];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < 32; r++)
                regs[r] <= '0;
        end else if (wb_hit) begin
            regs[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_inst   <= '0;
            out_rs     <= '0;
            out_rt     <= '0;
            out_rd     <= '0;
            out_wen    <= 1'b0;
            out_rdata1 <= '0;
            out_rdata2 <= '0;
            out_imm    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_inst   <= in_inst;
            out_rs     <= dec_rs;
            out_rt     <= dec_rt;
            out_rd     <= dec_rd;
            out_wen    <= dec_wen;
            out_rdata1 <= opnd1;
            out_rdata2 <= opnd2;
            out_imm    <= dec_imm;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_idecode_sb.sv
// Drives a bypassing 32-bit stage and a stalling 64-bit stage with shared stimulus,
// each compared against its own behavioural model.
module tb_idecode_sb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_inst = '0;
    logic        flush = 1'b0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [63:0] wb_data = '0;
    logic        out_ready = 1'b0;

    logic        a_in_ready, a_out_valid, a_out_wen;
    logic [31:0] a_out_inst, a_rd1, a_rd2, a_imm;
    logic [4:0]  a_rs, a_rt, a_rd;
    logic        b_in_ready, b_out_valid, b_out_wen;
    logic [31:0] b_out_inst;
    logic [63:0] b_rd1, b_rd2, b_imm;
    logic [4:0]  b_rs, b_rt, b_rd;

    idecode_sb #(.XLEN(32), .SB_W(2), .BYPASS(1'b1)) u_byp (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_inst(in_inst), .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr),
        .wb_data(wb_data[31:0]), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_inst(a_out_inst), .out_rs(a_rs), .out_rt(a_rt), .out_rd(a_rd),
        .out_wen(a_out_wen), .out_rdata1(a_rd1), .out_rdata2(a_rd2), .out_imm(a_imm)
    );

    idecode_sb #(.XLEN(64), .SB_W(2), .BYPASS(1'b0)) u_stall (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_inst(in_inst), .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr),
        .wb_data(wb_data), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_inst(b_out_inst), .out_rs(b_rs), .out_rt(b_rt), .out_rd(b_rd),
        .out_wen(b_out_wen), .out_rdata1(b_rd1), .out_rdata2(b_rd2), .out_imm(b_imm)
    );

    logic        o_ready [2];
    logic        o_valid [2];
    logic        o_wen   [2];
    logic [31:0] o_inst  [2];
    logic [4:0]  o_rs    [2];
    logic [4:0]  o_rt    [2];
    logic [4:0]  o_rd    [2];
    logic [63:0] o_rd1   [2];
    logic [63:0] o_rd2   [2];
    logic [63:0] o_imm   [2];

    assign o_ready[0] = a_in_ready;   assign o_ready[1] = b_in_ready;
    assign o_valid[0] = a_out_valid;  assign o_valid[1] = b_out_valid;
    assign o_wen[0]   = a_out_wen;    assign o_wen[1]   = b_out_wen;
    assign o_inst[0]  = a_out_inst;   assign o_inst[1]  = b_out_inst;
    assign o_rs[0]    = a_rs;         assign o_rs[1]    = b_rs;
    assign o_rt[0]    = a_rt;         assign o_rt[1]    = b_rt;
    assign o_rd[0]    = a_rd;         assign o_rd[1]    = b_rd;
    assign o_rd1[0]   = {32'b0, a_rd1}; assign o_rd1[1] = b_rd1;
    assign o_rd2[0]   = {32'b0, a_rd2}; assign o_rd2[1] = b_rd2;
    assign o_imm[0]   = {32'b0, a_imm}; assign o_imm[1] = b_imm;

    localparam int CNT_MAX = 3;
    bit          byp   [2] = '{1'b1, 1'b0};
    logic [63:0] xmask [2] = '{64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};

    logic [63:0] m_regs [2][32];
    int          m_cnt  [2][32];
    logic        m_valid [2];
    logic        m_wen   [2];
    logic [31:0] m_inst  [2];
    logic [4:0]  m_rs    [2];
    logic [4:0]  m_rt    [2];
    logic [4:0]  m_rd    [2];
    logic [63:0] m_rd1   [2];
    logic [63:0] m_rd2   [2];
    logic [63:0] m_imm   [2];
    logic        m_ready [2];
    logic        last_ready [2];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] f_rs(input logic [31:0] x);
        logic [5:0] op = x[31:26];
        return (op == 6'd2 || op == 6'd3) ? 5'd0 : x[25:21];
    endfunction

    function automatic logic [4:0] f_rt(input logic [31:0] x);
        logic [5:0] op = x[31:26];
        return (op == 6'd1 || op == 6'd2 || op == 6'd3 || op[5:3] == 3'd4) ? 5'd0 : x[20:16];
    endfunction

    function automatic logic [4:0] f_rd(input logic [31:0] x);
        logic [5:0] op = x[31:26];
        if (op == 6'd0) return x[15:11];
        if (op[5:3] == 3'd1 || op[5:3] == 3'd4) return x[20:16];
        if (op == 6'd1 || op == 6'd3) return 5'd31;
        return 5'd0;
    endfunction

    function automatic logic [63:0] f_imm(input logic [31:0] x);
        logic [5:0] op = x[31:26];
        if (op == 6'd12 || op == 6'd13 || op == 6'd14) return {48'b0, x[15:0]};
        if (op == 6'd2 || op == 6'd3) return {38'b0, x[25:0]};
        return {{48{x[15]}}, x[15:0]};
    endfunction

    function automatic logic src_busy(input int i, input logic [4:0] s);
        if (s == 5'd0 || m_cnt[i][s] == 0) return 1'b0;
        return !(byp[i] && wb_we && wb_addr == s && m_cnt[i][s] == 1);
    endfunction

    function automatic logic pred_ready(input int i);
        logic [4:0] rd  = f_rd(in_inst);
        logic       wen = (rd != 5'd0) && (in_inst != 32'd0);
        logic       hz  = src_busy(i, f_rs(in_inst)) || src_busy(i, f_rt(in_inst)) ||
                          (wen && m_cnt[i][rd] == CNT_MAX);
        return !flush && !hz && (!m_valid[i] || out_ready);
    endfunction

    function automatic logic [63:0] operand(input int i, input logic [4:0] s);
        if (s == 5'd0) return 64'd0;
        if (byp[i] && wb_we && wb_addr == s) return wb_data & xmask[i];
        return m_regs[i][s];
    endfunction

    task automatic model_reset(input int i);
        for (int r = 0; r < 32; r++) begin
            m_regs[i][r] = '0;
            m_cnt[i][r]  = 0;
        end
        m_valid[i] = 1'b0; m_wen[i] = 1'b0; m_inst[i] = '0;
        m_rs[i] = '0; m_rt[i] = '0; m_rd[i] = '0;
        m_rd1[i] = '0; m_rd2[i] = '0; m_imm[i] = '0;
    endtask

    task automatic model_advance(input int i);
        logic [4:0] rd   = f_rd(in_inst);
        logic       wen  = (rd != 5'd0) && (in_inst != 32'd0);
        logic       acc  = in_valid && m_ready[i];
        logic       wdec = wb_we && wb_addr != 5'd0 && m_cnt[i][wb_addr] != 0;
        logic       kdec = flush && m_valid[i] && m_wen[i];
        int         n;
        for (int r = 0; r < 32; r++) begin
            n = m_cnt[i][r];
            if (acc && wen && rd == 5'(r)) n++;
            if (wdec && wb_addr == 5'(r)) n--;
            if (kdec && m_rd[i] == 5'(r)) n--;
            m_cnt[i][r] = (n < 0) ? 0 : n;
        end
        if (flush) begin
            m_valid[i] = 1'b0;
        end else if (acc) begin
            m_valid[i] = 1'b1;
            m_inst[i]  = in_inst;
            m_rs[i]    = f_rs(in_inst);
            m_rt[i]    = f_rt(in_inst);
            m_rd[i]    = rd;
            m_wen[i]   = wen;
            m_rd1[i]   = operand(i, f_rs(in_inst));
            m_rd2[i]   = operand(i, f_rt(in_inst));
            m_imm[i]   = f_imm(in_inst) & xmask[i];
        end else if (out_ready) begin
            m_valid[i] = 1'b0;
        end
        if (wb_we && wb_addr != 5'd0)
            m_regs[i][wb_addr] = wb_data & xmask[i];
    endtask

    task automatic check_outputs(input int i);
        check($sformatf("i%0d out_valid", i),  64'(o_valid[i]), 64'(m_valid[i]));
        check($sformatf("i%0d out_inst", i),   64'(o_inst[i]),  64'(m_inst[i]));
        check($sformatf("i%0d out_rs", i),     64'(o_rs[i]),    64'(m_rs[i]));
        check($sformatf("i%0d out_rt", i),     64'(o_rt[i]),    64'(m_rt[i]));
        check($sformatf("i%0d out_rd", i),     64'(o_rd[i]),    64'(m_rd[i]));
        check($sformatf("i%0d out_wen", i),    64'(o_wen[i]),   64'(m_wen[i]));
        check($sformatf("i%0d out_rdata1", i), o_rd1[i],        m_rd1[i]);
        check($sformatf("i%0d out_rdata2", i), o_rd2[i],        m_rd2[i]);
        check($sformatf("i%0d out_imm", i),    o_imm[i],        m_imm[i]);
    endtask

    // Called just after a rising edge; leaves time just after the next rising edge.
    task automatic step();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            m_ready[i]    = pred_ready(i);
            last_ready[i] = o_ready[i];
            check($sformatf("i%0d in_ready", i), 64'(o_ready[i]), 64'(m_ready[i]));
        end
        for (int i = 0; i < 2; i++) model_advance(i);
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) check_outputs(i);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; flush = 1'b0; wb_we = 1'b0; out_ready = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            model_reset(i);
            check_outputs(i);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_in(input logic v, input logic [31:0] inst);
        in_valid = v;
        in_inst  = inst;
    endtask

    task automatic set_wb(input logic we, input logic [4:0] a, input logic [63:0] d);
        wb_we   = we;
        wb_addr = a;
        wb_data = d;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [5:0] op;
        case ($urandom_range(0, 11))
            0:  op = 6'b000000;
            1:  op = 6'b001001;
            2:  op = 6'b001100;
            3:  op = 6'b001101;
            4:  op = 6'b001110;
            5:  op = 6'b100011;
            6:  op = 6'b101011;
            7:  op = 6'b000010;
            8:  op = 6'b000011;
            9:  op = 6'b000001;
            10: op = 6'b000100;
            default: op = 6'($urandom);
        endcase
        if ($urandom_range(0, 15) == 0) return 32'd0;
        return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 11'($urandom)};
    endfunction

    initial begin
        #2;
        do_reset();

        // addiu r5,r0,7
        out_ready = 1'b1;
        set_in(1'b1, 32'h2405_0007);
        step();
        for (int i = 0; i < 2; i++) begin
            check("addiu valid", 64'(o_valid[i]), 64'd1);
            check("addiu rd",    64'(o_rd[i]),    64'd5);
            check("addiu wen",   64'(o_wen[i]),   64'd1);
            check("addiu imm",   o_imm[i],        64'd7);
        end

        // addu r6,r5,r5 waits on r5
        set_in(1'b1, 32'h00A5_3021);
        step();
        check("raw stall byp", 64'(last_ready[0]), 64'd0);
        check("raw stall nob", 64'(last_ready[1]), 64'd0);
        set_wb(1'b1, 5'd5, 64'd7);
        step();
        check("bypass accept", 64'(last_ready[0]), 64'd1);
        check("bypass rdata1", o_rd1[0], 64'd7);
        check("bypass rdata2", o_rd2[0], 64'd7);
        check("nobyp wb stall", 64'(last_ready[1]), 64'd0);
        set_wb(1'b0, 5'd0, 64'd0);
        step();
        check("nobyp accept", 64'(last_ready[1]), 64'd1);
        check("nobyp rdata1", o_rd1[1], 64'd7);
        check("nobyp rdata2", o_rd2[1], 64'd7);
        set_in(1'b0, 32'd0);
        step();

        // Scoreboard saturation on r9
        do_reset();
        out_ready = 1'b1;
        set_in(1'b1, 32'h8C09_0000);
        for (int k = 0; k < 3; k++) step();
        step();
        check("sat stall", 64'(last_ready[0]), 64'd0);
        set_wb(1'b1, 5'd9, 64'h1234);
        step();
        check("sat wb stall", 64'(last_ready[0]), 64'd0);
        set_wb(1'b0, 5'd0, 64'd0);
        step();
        check("sat resume", 64'(last_ready[0]), 64'd1);
        step();
        check("sat full again", 64'(last_ready[1]), 64'd0);

        // Immediate extension
        do_reset();
        out_ready = 1'b1;
        set_in(1'b1, 32'h3022_FFFF);
        step();
        check("andi imm32", o_imm[0], 64'h0000_0000_0000_FFFF);
        check("andi imm64", o_imm[1], 64'h0000_0000_0000_FFFF);
        set_in(1'b1, 32'h8C23_FFFC);
        step();
        check("lw imm32", o_imm[0], 64'h0000_0000_FFFF_FFFC);
        check("lw imm64", o_imm[1], 64'hFFFF_FFFF_FFFF_FFFC);
        check("lw rt",    64'(o_rt[0]), 64'd0);
        check("lw rd",    64'(o_rd[1]), 64'd3);

        // Flush of a held bundle writing r4
        do_reset();
        out_ready = 1'b0;
        set_in(1'b1, 32'h2404_0001);
        step();
        set_in(1'b0, 32'd0);
        step();
        check("held valid", 64'(o_valid[0]), 64'd1);
        flush = 1'b1;
        set_in(1'b1, 32'h2404_0001);
        step();
        check("flush ready", 64'(last_ready[0]), 64'd0);
        check("flush valid", 64'(o_valid[1]), 64'd0);
        flush = 1'b0;
        set_in(1'b1, 32'h0084_3821);
        step();
        check("post flush accept", 64'(last_ready[1]), 64'd1);
        check("post flush rd", 64'(o_rd[0]), 64'd7);

        // Reset while stalled
        set_in(1'b1, 32'h00E7_4021);
        step();
        check("pre reset stall", 64'(last_ready[0]), 64'd0);
        do_reset();
        check("rst valid", 64'(o_valid[0]), 64'd0);
        check("rst rd", 64'(o_rd[1]), 64'd0);

        // Random traffic
        for (int n = 0; n < 800; n++) begin
            set_in($urandom_range(0, 3) != 0, rand_inst());
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            if (flush)
                set_wb(1'b0, 5'd0, 64'd0);
            else
                set_wb($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), {$urandom, $urandom});
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
